// File: rtl/io_mmu_mp.sv
// Multi-port IOMMU: round-robin arbiter, shared fully-associative TLB (4K/2M/1G), Sv39 walker over L1.5.
// Optional performance counters are enabled with `define IO_MMU_PERF_CNT_EN.
module io_mmu_mp #(
  parameter int NUM_PORTS   = 2,
  parameter int TLB_ENTRIES = 8,
  parameter int VADDR       = 39,
  parameter int PADDR       = 40
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_PORTS-1:0]         req_val_i,
  output logic [NUM_PORTS-1:0]         req_rdy_o,
  input  logic [NUM_PORTS*VADDR-1:0]   req_vaddr_i,
  input  logic [NUM_PORTS-1:0]         req_store_i,
  output logic [NUM_PORTS-1:0]         res_val_o,
  output logic [PADDR-1:0]             res_paddr_o,
  output logic                         res_exc_o,
  input  logic                         tlb_en_i,
  input  logic [PADDR-13:0]            satp_ppn_i,
  input  logic                         flush_i,
  output logic                         l15_val_o,
  input  logic                         l15_ack_i,
  output logic [PADDR-1:0]             l15_address_o,
  input  logic                         l15_rvalid_i,
  input  logic [63:0]                  l15_rdata_i,
  output logic [31:0]                  hit_cnt_o,
  output logic [31:0]                  miss_cnt_o
);
  localparam int PW  = PADDR - 12;
  localparam int IDW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int EW  = $clog2(TLB_ENTRIES);
  localparam logic [1:0] SZ_4K = 2'd0, SZ_2M = 2'd1, SZ_1G = 2'd2;

  typedef enum logic [2:0] {IDLE, LOOKUP, WALK_REQ, WALK_WAIT, RESP} state_e;
  typedef struct packed {
    logic          v;
    logic [26:0]   vpn;
    logic [PW-1:0] ppn;
    logic [1:0]    sz;
    logic          w;
    logic          d;
  } tlb_ent_t;

  state_e                      state_q, state_d;
  tlb_ent_t [TLB_ENTRIES-1:0]  tlb_q;
  logic [IDW-1:0]              rr_q, rr_d, port_q, gnt_id;
  logic [EW-1:0]               victim_q, hit_idx, free_idx, inst_idx;
  logic [VADDR-1:0]            vaddr_q;
  logic                        store_q, flushed_q, flushed_d, rexc_q, rexc_d;
  logic [1:0]                  level_q, level_d;
  logic [PW-1:0]               base_q, base_d;
  logic [PADDR-1:0]            rpa_q, rpa_d;
  logic [TLB_ENTRIES-1:0]      match;
  logic                        hit_any, free_any, gnt_found, grant_en, install, tr_hit, walk_start;
  logic [26:0]                 vpn;
  logic [8:0]                  vpn_seg;
  logic [PW-1:0]               pte_ppn;
  logic                        pte_fault, pte_leaf, pte_misal;
  tlb_ent_t                    hit_e, new_e;

  function automatic logic [PADDR-1:0] mk_pa(input logic [PW-1:0] ppn, input logic [1:0] sz,
                                             input logic [VADDR-1:0] va);
    logic [PADDR-1:0] pa;
    pa = {ppn, va[11:0]};
    if (sz == SZ_2M)      pa[20:12] = va[20:12];
    else if (sz == SZ_1G) pa[29:12] = va[29:12];
    return pa;
  endfunction

  assign vpn = vaddr_q[38:12];

  // Superpage entries only compare the VPN bits above their page size.
  for (genvar i = 0; i < TLB_ENTRIES; i++) begin : g_match
    assign match[i] = tlb_q[i].v && (tlb_q[i].vpn[26:18] == vpn[26:18]) &&
                      ((tlb_q[i].sz == SZ_1G) || ((tlb_q[i].vpn[17:9] == vpn[17:9]) &&
                       ((tlb_q[i].sz == SZ_2M) || (tlb_q[i].vpn[8:0] == vpn[8:0]))));
  end

  always_comb begin
    hit_any = 1'b0; hit_idx = '0; free_any = 1'b0; free_idx = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (match[i] && !hit_any)     begin hit_any = 1'b1;  hit_idx = EW'(i);  end
      if (!tlb_q[i].v && !free_any) begin free_any = 1'b1; free_idx = EW'(i); end
    end
  end
  assign hit_e    = tlb_q[hit_idx];
  assign inst_idx = free_any ? free_idx : victim_q;

  always_comb begin
    gnt_found = 1'b0; gnt_id = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      int idx;
      idx = (int'(rr_q) + k) % NUM_PORTS;
      if (!gnt_found && req_val_i[idx]) begin gnt_found = 1'b1; gnt_id = IDW'(idx); end
    end
  end

  always_comb begin
    case (level_q)
      2'd2:    vpn_seg = vaddr_q[38:30];
      2'd1:    vpn_seg = vaddr_q[29:21];
      default: vpn_seg = vaddr_q[20:12];
    endcase
  end

  assign pte_ppn   = l15_rdata_i[PADDR-3:10];
  assign pte_fault = !l15_rdata_i[0] || (!l15_rdata_i[1] && l15_rdata_i[2]);
  assign pte_leaf  = l15_rdata_i[1] || l15_rdata_i[3];
  assign pte_misal = ((level_q == 2'd2) && (pte_ppn[17:0] != '0)) ||
                     ((level_q == 2'd1) && (pte_ppn[8:0]  != '0));
  assign new_e     = '{v: 1'b1, vpn: vpn, ppn: pte_ppn, sz: level_q,
                       w: l15_rdata_i[2], d: l15_rdata_i[7]};

  always_comb begin
    state_d = state_q; rr_d = rr_q; level_d = level_q; base_d = base_q;
    flushed_d = flushed_q; rpa_d = rpa_q; rexc_d = rexc_q;
    grant_en = 1'b0; install = 1'b0; tr_hit = 1'b0; walk_start = 1'b0;
    req_rdy_o = '0; res_val_o = '0; res_paddr_o = '0; res_exc_o = 1'b0;
    l15_val_o = 1'b0; l15_address_o = '0;
    if (flush_i && (state_q == WALK_REQ || state_q == WALK_WAIT)) flushed_d = 1'b1;
    case (state_q)
      IDLE: grant_en = 1'b1;
      LOOKUP: begin
        if (!tlb_en_i) begin
          res_val_o[port_q] = 1'b1;
          res_paddr_o       = PADDR'(vaddr_q);
          grant_en          = 1'b1;
        end else if (hit_any && !flush_i) begin
          res_val_o[port_q] = 1'b1;
          res_paddr_o       = mk_pa(hit_e.ppn, hit_e.sz, vaddr_q);
          res_exc_o         = store_q && !(hit_e.w && hit_e.d);
          grant_en          = 1'b1;
          tr_hit            = 1'b1;
        end else begin
          state_d = WALK_REQ; level_d = 2'd2; base_d = satp_ppn_i;
          flushed_d = 1'b0; walk_start = 1'b1;
        end
      end
      WALK_REQ: begin
        l15_val_o     = 1'b1;
        l15_address_o = {base_q, vpn_seg, 3'b000};
        if (l15_ack_i) state_d = WALK_WAIT;
      end
      WALK_WAIT: begin
        if (l15_rvalid_i) begin
          if (pte_fault || (pte_leaf && pte_misal) || (!pte_leaf && level_q == 2'd0)) begin
            state_d = RESP; rexc_d = 1'b1; rpa_d = '0;
          end else if (pte_leaf) begin
            state_d = RESP;
            rpa_d   = mk_pa(pte_ppn, level_q, vaddr_q);
            rexc_d  = store_q && !(l15_rdata_i[2] && l15_rdata_i[7]);
            install = !flush_i && !flushed_q;
          end else begin
            state_d = WALK_REQ; base_d = pte_ppn; level_d = level_q - 2'd1;
          end
        end
      end
      RESP: begin
        res_val_o[port_q] = 1'b1;
        res_paddr_o       = rpa_q;
        res_exc_o         = rexc_q;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A hit (or bypass) frees the pipe, so the next grant overlaps the response.
    if (grant_en) begin
      state_d = IDLE;
      if (gnt_found) begin
        req_rdy_o[gnt_id] = 1'b1;
        rr_d    = (int'(gnt_id) == NUM_PORTS - 1) ? '0 : IDW'(int'(gnt_id) + 1);
        state_d = LOOKUP;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE; rr_q <= '0; victim_q <= '0; port_q <= '0; vaddr_q <= '0;
      store_q <= 1'b0; level_q <= '0; base_q <= '0; flushed_q <= 1'b0;
      rpa_q <= '0; rexc_q <= 1'b0; tlb_q <= '0;
    end else begin
      state_q <= state_d; rr_q <= rr_d; level_q <= level_d; base_q <= base_d;
      flushed_q <= flushed_d; rpa_q <= rpa_d; rexc_q <= rexc_d;
      if (|req_rdy_o) begin
        port_q  <= gnt_id;
        vaddr_q <= req_vaddr_i[int'(gnt_id)*VADDR +: VADDR];
        store_q <= req_store_i[gnt_id];
      end
      if (flush_i) begin
        for (int i = 0; i < TLB_ENTRIES; i++) tlb_q[i].v <= 1'b0;
      end else if (install) begin
        tlb_q[inst_idx] <= new_e;
        if (!free_any) victim_q <= victim_q + 1'b1;
      end
    end
  end

`ifdef IO_MMU_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q <= '0; miss_cnt_q <= '0;
    end else begin
      if (tr_hit && !(&hit_cnt_q))      hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (walk_start && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = tr_hit ^ walk_start;
  assign hit_cnt_o   = '0;
  assign miss_cnt_o  = '0;
`endif

  logic unused_pte;
  assign unused_pte = ^{l15_rdata_i[63:PADDR-2], l15_rdata_i[6:4]};
endmodule

// File: tb/tb_io_mmu_mp.sv
// Directed bench for io_mmu_mp: vector table plus arbitration, replacement, flush and reset sequences.
module tb_io_mmu_mp;
  localparam int NP = 2, VA = 39, PA = 40;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic [NP-1:0]     req_val_i, req_rdy_o, req_store_i, res_val_o;
  logic [NP*VA-1:0]  req_vaddr_i;
  logic [PA-1:0]     res_paddr_o, l15_address_o;
  logic              res_exc_o, tlb_en_i, flush_i, l15_val_o, l15_ack_i, l15_rvalid_i;
  logic [PA-13:0]    satp_ppn_i;
  logic [63:0]       l15_rdata_i;
  logic [31:0]       hit_cnt_o, miss_cnt_o;

  logic              flush_main, flush_resp, flush_in_wait, flush_on_rv, mem_hold;
  int                checks, errors, nreads, exp_hit, exp_miss;
  logic [PA-1:0]     addr_log[$];
  logic [PA-1:0]     resp_a;

  assign flush_i = flush_main | flush_resp;
  always #5 clk = ~clk;

  io_mmu_mp #(.NUM_PORTS(NP), .TLB_ENTRIES(8), .VADDR(VA), .PADDR(PA)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_val_i(req_val_i), .req_rdy_o(req_rdy_o),
    .req_vaddr_i(req_vaddr_i), .req_store_i(req_store_i), .res_val_o(res_val_o),
    .res_paddr_o(res_paddr_o), .res_exc_o(res_exc_o), .tlb_en_i(tlb_en_i),
    .satp_ppn_i(satp_ppn_i), .flush_i(flush_i), .l15_val_o(l15_val_o), .l15_ack_i(l15_ack_i),
    .l15_address_o(l15_address_o), .l15_rvalid_i(l15_rvalid_i), .l15_rdata_i(l15_rdata_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o));

  function automatic logic [63:0] pte_at(input logic [PA-1:0] a);
    case (a)
      40'h00_8000_4008: return (64'h80005 << 10) | 64'h01;
      40'h00_8000_5000: return (64'h80006 << 10) | 64'h01;
      40'h00_8000_6008: return (64'hABCDE << 10) | 64'h87;
      40'h00_9000_0008: return (64'h40000 << 10) | 64'h87;
      40'h00_A000_0008: return (64'h40001 << 10) | 64'h87;
      40'h00_B000_0000: return (64'hB0001 << 10) | 64'h01;
      40'h00_B000_1000: return (64'hB0002 << 10) | 64'h01;
      40'h00_B000_2028: return (64'h12345 << 10) | 64'h07;
      default: begin
        if (a[39:12] == 28'hC0000 && a[11:3] < 9'd9) return (64'(a[11:3]) << 28) | 64'h87;
        return 64'h0;
      end
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // L1.5 memory model: ack on first sight of a request, data one cycle later.
  initial begin
    l15_ack_i = 1'b0; l15_rvalid_i = 1'b0; l15_rdata_i = '0; flush_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (l15_val_o && !mem_hold && rst_ni) begin
        resp_a = l15_address_o; addr_log.push_back(resp_a); nreads++;
        l15_ack_i = 1'b1;
        @(negedge clk); l15_ack_i = 1'b0;
        if (flush_in_wait) begin flush_resp = 1'b1; @(negedge clk); flush_resp = 1'b0; end
        l15_rvalid_i = 1'b1; l15_rdata_i = pte_at(resp_a); flush_resp = flush_on_rv;
        @(negedge clk); l15_rvalid_i = 1'b0; flush_resp = 1'b0;
      end
    end
  end

  task automatic do_flush();
    @(negedge clk); flush_main = 1'b1;
    @(negedge clk); flush_main = 1'b0;
  endtask

  task automatic txn(input int p, input logic [VA-1:0] va, input logic st, input logic [PA-1:0] epa,
                     input logic cpa, input logic eexc, input int erd, input string nm);
    int cyc, n0;
    logic [NP-1:0] oh;
    oh = NP'(1 << p);
    @(negedge clk);
    addr_log.delete(); n0 = nreads;
    req_val_i = oh; req_store_i = st ? oh : '0; req_vaddr_i[p*VA +: VA] = va;
    #1; cyc = 0;
    while (!req_rdy_o[p] && cyc < 50) begin @(negedge clk); #1; cyc++; end
    if (!req_rdy_o[p]) begin
      checks++; errors++;
      $display("FAIL %s grant: got no grant within 50 cycles", nm);
      req_val_i = '0; req_store_i = '0;
      return;
    end
    @(negedge clk); #1; req_val_i = '0; req_store_i = '0;
    cyc = 1;
    while (res_val_o == '0 && cyc < 300) begin @(negedge clk); #1; cyc++; end
    chk({nm, " res_val"}, 64'(res_val_o), 64'(oh));
    if (res_val_o == oh) begin
      if (cpa) chk({nm, " paddr"}, 64'(res_paddr_o), 64'(epa));
      chk({nm, " exc"}, 64'(res_exc_o), 64'(eexc));
      chk({nm, " l15 reads"}, 64'(nreads - n0), 64'(erd));
      if (erd == 0) chk({nm, " latency"}, 64'(cyc), 64'd1);
    end
    if (erd == 0 && tlb_en_i) exp_hit++;
    if (erd > 0) exp_miss++;
  endtask

  typedef struct {
    logic en; logic [27:0] satp; logic fl; int port; logic [VA-1:0] va; logic st;
    logic [PA-1:0] pa; logic cpa; logic exc; int rd;
    logic [PA-1:0] a0; logic [PA-1:0] a1; logic [PA-1:0] a2; string nm;
  } vec_t;
  vec_t tv[9];

  initial begin
    logic [NP-1:0] g[4];
    logic [PA-1:0] ea[3];
    logic [VA-1:0] pva;
    int cyc;
    checks = 0; errors = 0; nreads = 0; exp_hit = 0; exp_miss = 0;
    flush_main = 1'b0; flush_in_wait = 1'b0; flush_on_rv = 1'b0; mem_hold = 1'b0;
    req_val_i = '0; req_store_i = '0; req_vaddr_i = '0; tlb_en_i = 1'b0; satp_ppn_i = '0;
    rst_ni = 1'b0;

    tv[0] = '{1'b0, 28'h0,     1'b0, 0, 39'h12345678, 1'b0, 40'h0012345678, 1'b1, 1'b0, 0, 40'h0, 40'h0, 40'h0, "bypass"};
    tv[1] = '{1'b1, 28'h80004, 1'b0, 0, 39'h40001234, 1'b0, 40'hABCDE234,    1'b1, 1'b0, 3,
              40'h80004008, 40'h80005000, 40'h80006008, "walk4k"};
    tv[2] = '{1'b1, 28'h80004, 1'b0, 0, 39'h40001234, 1'b0, 40'hABCDE234,    1'b1, 1'b0, 0, 40'h0, 40'h0, 40'h0, "hit4k"};
    tv[3] = '{1'b1, 28'h90000, 1'b0, 0, 39'h4ABCDEF0, 1'b0, 40'h4ABCDEF0,    1'b1, 1'b0, 1, 40'h90000008, 40'h0, 40'h0, "walk1g"};
    tv[4] = '{1'b1, 28'h90000, 1'b0, 0, 39'h7FFFFFF0, 1'b0, 40'h7FFFFFF0,    1'b1, 1'b0, 0, 40'h0, 40'h0, 40'h0, "hit1g"};
    tv[5] = '{1'b1, 28'hA0000, 1'b1, 0, 39'h4ABCDEF0, 1'b0, 40'h0,           1'b1, 1'b1, 1, 40'hA0000008, 40'h0, 40'h0, "misalign1g"};
    tv[6] = '{1'b1, 28'hB0000, 1'b0, 0, 39'h5000,     1'b1, 40'h0,           1'b0, 1'b1, 3,
              40'hB0000000, 40'hB0001000, 40'hB0002028, "st_walk_nodirty"};
    tv[7] = '{1'b1, 28'hB0000, 1'b0, 1, 39'h5000,     1'b0, 40'h12345000,    1'b1, 1'b0, 0, 40'h0, 40'h0, 40'h0, "ld_hit_port1"};
    tv[8] = '{1'b1, 28'hB0000, 1'b0, 0, 39'h5ABC,     1'b1, 40'h0,           1'b0, 1'b1, 0, 40'h0, 40'h0, 40'h0, "st_hit_nodirty"};

    repeat (3) @(negedge clk);
    chk("rst req_rdy", 64'(req_rdy_o), 64'h0);
    chk("rst res_val", 64'(res_val_o), 64'h0);
    chk("rst res_paddr", 64'(res_paddr_o), 64'h0);
    chk("rst res_exc", 64'(res_exc_o), 64'h0);
    chk("rst l15_val", 64'(l15_val_o), 64'h0);
    chk("rst l15_addr", 64'(l15_address_o), 64'h0);
    chk("rst hit_cnt", 64'(hit_cnt_o), 64'h0);
    chk("rst miss_cnt", 64'(miss_cnt_o), 64'h0);
    rst_ni = 1'b1;

    for (int i = 0; i < 9; i++) begin
      tlb_en_i = tv[i].en; satp_ppn_i = tv[i].satp;
      if (tv[i].fl) do_flush();
      txn(tv[i].port, tv[i].va, tv[i].st, tv[i].pa, tv[i].cpa, tv[i].exc, tv[i].rd, tv[i].nm);
      ea[0] = tv[i].a0; ea[1] = tv[i].a1; ea[2] = tv[i].a2;
      for (int k = 0; k < tv[i].rd && k < 3; k++)
        if (k < addr_log.size()) chk({tv[i].nm, " pte addr"}, 64'(addr_log[k]), 64'(ea[k]));
    end

    // Back-to-back hits from both ports; pointer is at port1 after the preload grant of port0.
    tlb_en_i = 1'b1; satp_ppn_i = 28'h90000;
    do_flush();
    txn(0, 39'h40000000, 1'b0, 40'h40000000, 1'b1, 1'b0, 1, "arb_preload");
    @(negedge clk);
    req_vaddr_i[0 +: VA] = 39'h40000000; req_vaddr_i[VA +: VA] = 39'h50000000; req_val_i = 2'b11;
    g[0] = 2'b10; g[1] = 2'b01; g[2] = 2'b10; g[3] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("arb grant", 64'(req_rdy_o), 64'(g[i]));
      if (i > 0) begin
        chk("arb res_val", 64'(res_val_o), 64'(g[i-1]));
        chk("arb paddr", 64'(res_paddr_o), (g[i-1] == 2'b10) ? 64'h50000000 : 64'h40000000);
      end
      @(negedge clk);
    end
    req_val_i = '0; #1;
    chk("arb last res_val", 64'(res_val_o), 64'h1);
    exp_hit += 4;
    repeat (2) @(negedge clk);
    // Miss on port1 blocks all grants until its response.
    req_vaddr_i[VA +: VA] = 39'h80000000; req_val_i = 2'b11; #1;
    chk("arb miss grant", 64'(req_rdy_o), 64'h2);
    @(negedge clk); #1;
    cyc = 0;
    while (res_val_o == '0 && cyc < 100) begin
      chk("arb blocked rdy", 64'(req_rdy_o), 64'h0);
      @(negedge clk); #1; cyc++;
    end
    chk("arb miss res_val", 64'(res_val_o), 64'h2);
    chk("arb miss exc", 64'(res_exc_o), 64'h1);
    chk("arb rdy in resp", 64'(req_rdy_o), 64'h0);
    @(negedge clk); #1;
    chk("arb rdy after resp", 64'(req_rdy_o), 64'h1);
    req_val_i = '0;
    exp_miss += 1;

    // Replacement: nine 1G pages into eight entries, the ninth overwrites entry 0.
    satp_ppn_i = 28'hC0000;
    do_flush();
    for (int k = 0; k < 9; k++) begin
      pva = 39'(k) << 30;
      txn(0, pva, 1'b0, 40'(k) << 30, 1'b1, 1'b0, 1, "fill");
    end
    txn(0, 39'(1) << 30, 1'b0, 40'(1) << 30, 1'b1, 1'b0, 0, "repl page1 hit");
    txn(0, 39'(8) << 30, 1'b0, 40'(8) << 30, 1'b1, 1'b0, 0, "repl page8 hit");
    flush_in_wait = 1'b1;
    txn(0, 39'h0, 1'b0, 40'h0, 1'b1, 1'b0, 1, "repl page0 evicted");
    flush_in_wait = 1'b0;
    txn(0, 39'h0, 1'b0, 40'h0, 1'b1, 1'b0, 1, "flush_wait rewalk");
    txn(0, 39'h0, 1'b0, 40'h0, 1'b1, 1'b0, 0, "page0 hit");
    flush_on_rv = 1'b1;
    txn(0, 39'(2) << 30, 1'b0, 40'(2) << 30, 1'b1, 1'b0, 1, "flush_install walk");
    flush_on_rv = 1'b0;
    txn(0, 39'(2) << 30, 1'b0, 40'(2) << 30, 1'b1, 1'b0, 1, "flush_install rewalk");

`ifdef IO_MMU_PERF_CNT_EN
    chk("hit_cnt", 64'(hit_cnt_o), 64'(exp_hit));
    chk("miss_cnt", 64'(miss_cnt_o), 64'(exp_miss));
`else
    chk("hit_cnt tied", 64'(hit_cnt_o), 64'h0);
    chk("miss_cnt tied", 64'(miss_cnt_o), 64'h0);
`endif

    // Reset in the middle of a walk drops the L1.5 request immediately.
    mem_hold = 1'b1;
    @(negedge clk);
    req_vaddr_i[0 +: VA] = 39'(3) << 30; req_val_i = 2'b01;
    @(negedge clk); req_val_i = '0;
    cyc = 0;
    while (!l15_val_o && cyc < 20) begin @(negedge clk); cyc++; end
    chk("midwalk l15_val up", 64'(l15_val_o), 64'h1);
    #2 rst_ni = 1'b0;
    #1;
    chk("midwalk reset l15_val", 64'(l15_val_o), 64'h0);
    chk("midwalk reset l15_addr", 64'(l15_address_o), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
